// File: rtl/riscv_wb_stage_pkg.sv
// Shared writeback configuration: datapath width, source-select, load funct3 and FSM encodings.
package riscv_wb_stage_pkg;

  localparam int XLEN_DEF = 32;

  typedef enum logic [1:0] {
    SRC_ALU = 2'b00,
    SRC_MEM = 2'b01,
    SRC_PC4 = 2'b10,
    SRC_IMM = 2'b11
  } wb_src_e;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;

  typedef enum logic {
    ST_IDLE     = 1'b0,
    ST_WAIT_MEM = 1'b1
  } wb_state_e;

endpackage

// File: rtl/riscv_wb_stage_load_align.sv
// Combinational load extraction: picks the byte/halfword/word out of an aligned data word and extends it.
module riscv_load_align
  import riscv_wb_stage_pkg::*;
#(
  parameter int XLEN = XLEN_DEF
) (
  input  logic [XLEN-1:0] i_rdata,
  input  logic [2:0]      i_funct3,
  input  logic [1:0]      i_addr_lsb,
  output logic [XLEN-1:0] o_data,
  output logic            o_illegal
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  assign byte_sel = i_rdata[{i_addr_lsb, 3'b000} +: 8];
  assign half_sel = i_rdata[{i_addr_lsb[1], 4'b0000} +: 16];

  always_comb begin
    o_data    = '0;
    o_illegal = 1'b0;
    case (i_funct3)
      F3_LB:   o_data = {{(XLEN-8){byte_sel[7]}}, byte_sel};
      F3_LH:   o_data = {{(XLEN-16){half_sel[15]}}, half_sel};
      F3_LW:   o_data = i_rdata;
      F3_LBU:  o_data = {{(XLEN-8){1'b0}}, byte_sel};
      F3_LHU:  o_data = {{(XLEN-16){1'b0}}, half_sel};
      default: o_illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/riscv_wb_stage.sv
// RISC-V writeback stage: selects the result, waits for late load data, drives a registered regfile write.
// Optional retired-instruction counter o_wb_instret when RISCV_WB_INSTRET_EN is defined.
module riscv_wb_stage
  import riscv_wb_stage_pkg::*;
#(
  parameter int XLEN = XLEN_DEF
) (
  input  logic            i_clk,
  input  logic            i_rstn,
  input  logic            i_wb_valid,
  output logic            o_wb_ready,
  input  logic            i_wb_rd_wen,
  input  logic [4:0]      i_wb_rd_addr,
  input  logic [1:0]      i_wb_src_sel,
  input  logic [XLEN-1:0] i_wb_alu_result,
  input  logic [XLEN-1:0] i_wb_pc_plus4,
  input  logic [XLEN-1:0] i_wb_imm,
  input  logic [2:0]      i_wb_funct3,
  input  logic [1:0]      i_wb_addr_lsb,
  input  logic            i_wb_mem_rvalid,
  input  logic [XLEN-1:0] i_wb_mem_rdata,
  input  logic            i_wb_flush,
  output logic            o_regfile_rd_wen,
  output logic [4:0]      o_regfile_rd_addr,
  output logic [XLEN-1:0] o_regfile_rd_data,
  output logic            o_wb_illegal
`ifdef RISCV_WB_INSTRET_EN
  ,
  output logic [63:0]     o_wb_instret
`endif
);

  wb_state_e       state_q, state_d;
  logic            cap_wen_q, cap_wen_d;
  logic [4:0]      cap_addr_q, cap_addr_d;
  logic [2:0]      cap_funct3_q, cap_funct3_d;
  logic [1:0]      cap_lsb_q, cap_lsb_d;

  logic            rd_wen_q, rd_wen_d;
  logic [4:0]      rd_addr_q, rd_addr_d;
  logic [XLEN-1:0] rd_data_q, rd_data_d;
  logic            illegal_q, illegal_d;

  logic            accept;
  logic            is_load;
  logic            in_wait;
  logic            done;
  logic            done_load;
  logic            fld_wen;
  logic [4:0]      fld_addr;
  logic [XLEN-1:0] result;

  logic [2:0]      la_funct3;
  logic [1:0]      la_lsb;
  logic [XLEN-1:0] la_data;
  logic            la_illegal;

  assign in_wait    = (state_q == ST_WAIT_MEM);
  assign o_wb_ready = (state_q == ST_IDLE);
  assign accept     = i_wb_valid && o_wb_ready && !i_wb_flush;
  assign is_load    = (i_wb_src_sel == SRC_MEM);

  // While waiting, the load type comes from the captured fields, not the live MEM/WB bus.
  assign la_funct3 = in_wait ? cap_funct3_q : i_wb_funct3;
  assign la_lsb    = in_wait ? cap_lsb_q    : i_wb_addr_lsb;

  riscv_load_align #(.XLEN(XLEN)) u_load_align (
    .i_rdata    (i_wb_mem_rdata),
    .i_funct3   (la_funct3),
    .i_addr_lsb (la_lsb),
    .o_data     (la_data),
    .o_illegal  (la_illegal)
  );

  always_comb begin
    state_d      = state_q;
    cap_wen_d    = cap_wen_q;
    cap_addr_d   = cap_addr_q;
    cap_funct3_d = cap_funct3_q;
    cap_lsb_d    = cap_lsb_q;
    done         = 1'b0;
    done_load    = 1'b0;
    fld_wen      = i_wb_rd_wen;
    fld_addr     = i_wb_rd_addr;
    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          if (is_load && !i_wb_mem_rvalid) begin
            cap_wen_d    = i_wb_rd_wen;
            cap_addr_d   = i_wb_rd_addr;
            cap_funct3_d = i_wb_funct3;
            cap_lsb_d    = i_wb_addr_lsb;
            state_d      = ST_WAIT_MEM;
          end else begin
            done      = 1'b1;
            done_load = is_load;
          end
        end
      end
      ST_WAIT_MEM: begin
        fld_wen  = cap_wen_q;
        fld_addr = cap_addr_q;
        if (i_wb_flush) begin
          cap_wen_d = 1'b0;
          state_d   = ST_IDLE;
        end else if (i_wb_mem_rvalid) begin
          done      = 1'b1;
          done_load = 1'b1;
          state_d   = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    result = la_data;
    if (!in_wait) begin
      case (i_wb_src_sel)
        SRC_ALU: result = i_wb_alu_result;
        SRC_PC4: result = i_wb_pc_plus4;
        SRC_IMM: result = i_wb_imm;
        default: result = la_data;
      endcase
    end
  end

  // An illegal load still updates addr/data (data forced to 0 by the aligner) but never writes.
  always_comb begin
    rd_wen_d  = 1'b0;
    illegal_d = 1'b0;
    rd_addr_d = rd_addr_q;
    rd_data_d = rd_data_q;
    if (done) begin
      illegal_d = done_load && la_illegal;
      rd_wen_d  = fld_wen && (fld_addr != 5'd0) && !(done_load && la_illegal);
      rd_addr_d = fld_addr;
      rd_data_d = result;
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_rstn) begin
      state_q      <= ST_IDLE;
      cap_wen_q    <= 1'b0;
      cap_addr_q   <= '0;
      cap_funct3_q <= '0;
      cap_lsb_q    <= '0;
      rd_wen_q     <= 1'b0;
      rd_addr_q    <= '0;
      rd_data_q    <= '0;
      illegal_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      cap_wen_q    <= cap_wen_d;
      cap_addr_q   <= cap_addr_d;
      cap_funct3_q <= cap_funct3_d;
      cap_lsb_q    <= cap_lsb_d;
      rd_wen_q     <= rd_wen_d;
      rd_addr_q    <= rd_addr_d;
      rd_data_q    <= rd_data_d;
      illegal_q    <= illegal_d;
    end
  end

  assign o_regfile_rd_wen  = rd_wen_q;
  assign o_regfile_rd_addr = rd_addr_q;
  assign o_regfile_rd_data = rd_data_q;
  assign o_wb_illegal      = illegal_q;

`ifdef RISCV_WB_INSTRET_EN
  logic [63:0] instret_q, instret_d;

  // Counts completions, including x0 writes and illegal loads; wraps naturally.
  assign instret_d = done ? instret_q + 64'd1 : instret_q;

  always_ff @(posedge i_clk) begin
    if (!i_rstn) instret_q <= '0;
    else         instret_q <= instret_d;
  end

  assign o_wb_instret = instret_q;
`endif

endmodule

// File: tb/tb_riscv_wb_stage.sv
// Directed bench for riscv_wb_stage with a behavioural reference model and per-cycle comparison.
module tb_riscv_wb_stage;
  localparam int XLEN = 32;

  logic            clk = 1'b0;
  logic            rstn;
  logic            valid, rd_wen, rvalid, flush;
  logic [4:0]      rd_addr;
  logic [1:0]      src, lsb;
  logic [2:0]      f3;
  logic [XLEN-1:0] alu, pc4, imm, rdata;
  logic            ready, o_wen, o_ill;
  logic [4:0]      o_addr;
  logic [XLEN-1:0] o_data;
`ifdef RISCV_WB_INSTRET_EN
  logic [63:0]     o_instret;
`endif

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  riscv_wb_stage #(.XLEN(XLEN)) dut (
    .i_clk             (clk),
    .i_rstn            (rstn),
    .i_wb_valid        (valid),
    .o_wb_ready        (ready),
    .i_wb_rd_wen       (rd_wen),
    .i_wb_rd_addr      (rd_addr),
    .i_wb_src_sel      (src),
    .i_wb_alu_result   (alu),
    .i_wb_pc_plus4     (pc4),
    .i_wb_imm          (imm),
    .i_wb_funct3       (f3),
    .i_wb_addr_lsb     (lsb),
    .i_wb_mem_rvalid   (rvalid),
    .i_wb_mem_rdata    (rdata),
    .i_wb_flush        (flush),
    .o_regfile_rd_wen  (o_wen),
    .o_regfile_rd_addr (o_addr),
    .o_regfile_rd_data (o_data),
    .o_wb_illegal      (o_ill)
`ifdef RISCV_WB_INSTRET_EN
    ,
    .o_wb_instret      (o_instret)
`endif
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference load extraction using shifts and masks on the data word.
  function automatic logic [31:0] m_load(input logic [31:0] w, input logic [2:0] fn,
                                         input logic [1:0] off, output bit bad);
    logic [31:0] b, h;
    b   = (w >> (8 * off)) & 32'hFF;
    h   = (w >> (16 * off[1])) & 32'hFFFF;
    bad = 1'b0;
    case (fn)
      3'd0:    return (b >= 32'd128) ? b - 32'd256 : b;
      3'd1:    return (h >= 32'd32768) ? h - 32'd65536 : h;
      3'd2:    return w;
      3'd4:    return b;
      3'd5:    return h;
      default: begin bad = 1'b1; return 32'd0; end
    endcase
  endfunction

  bit          m_live = 1'b0;
  bit          m_pend;
  bit          p_wen;
  logic [4:0]  p_addr;
  logic [2:0]  p_f3;
  logic [1:0]  p_lsb;
  bit          e_wen, e_ill;
  logic [4:0]  e_addr;
  logic [31:0] e_data;
  logic [63:0] e_instret;

  task automatic m_complete(input bit wen, input logic [4:0] addr, input bit ld,
                            input logic [31:0] val, input bit bad);
    e_instret = e_instret + 64'd1;
    e_addr    = addr;
    e_data    = val;
    e_ill     = ld && bad;
    e_wen     = wen && (addr != 5'd0) && !(ld && bad);
  endtask

  always @(posedge clk) begin
    bit          bad;
    logic [31:0] v;
    if (!rstn) begin
      m_live = 1'b1; m_pend = 1'b0; p_wen = 1'b0; p_addr = '0; p_f3 = '0; p_lsb = '0;
      e_wen = 1'b0; e_ill = 1'b0; e_addr = '0; e_data = '0; e_instret = '0;
    end else if (m_live) begin
      e_wen = 1'b0;
      e_ill = 1'b0;
      if (m_pend) begin
        if (flush) m_pend = 1'b0;
        else if (rvalid) begin
          v = m_load(rdata, p_f3, p_lsb, bad);
          m_complete(p_wen, p_addr, 1'b1, v, bad);
          m_pend = 1'b0;
        end
      end else if (valid && !flush) begin
        if (src == 2'b01 && !rvalid) begin
          m_pend = 1'b1; p_wen = rd_wen; p_addr = rd_addr; p_f3 = f3; p_lsb = lsb;
        end else begin
          bad = 1'b0;
          case (src)
            2'b00:   v = alu;
            2'b10:   v = pc4;
            2'b11:   v = imm;
            default: v = m_load(rdata, f3, lsb, bad);
          endcase
          m_complete(rd_wen, rd_addr, src == 2'b01, v, bad);
        end
      end
    end
  end

  always @(negedge clk) begin
    if (m_live) begin
      chk("ready",   ready,  !m_pend);
      chk("rd_wen",  o_wen,  e_wen);
      chk("rd_addr", o_addr, e_addr);
      chk("rd_data", o_data, e_data);
      chk("illegal", o_ill,  e_ill);
`ifdef RISCV_WB_INSTRET_EN
      chk("instret", o_instret, e_instret);
`endif
    end
  end

  task automatic set_in(input logic v, input logic [1:0] s, input logic w, input logic [4:0] rd,
                        input logic [31:0] a, input logic [2:0] fn, input logic [1:0] off,
                        input logic rv, input logic [31:0] rd_word);
    valid = v; src = s; rd_wen = w; rd_addr = rd; alu = a;
    f3 = fn; lsb = off; rvalid = rv; rdata = rd_word; flush = 1'b0;
  endtask

  task automatic idle_in();
    set_in(1'b0, 2'b00, 1'b0, 5'd0, 32'd0, 3'd0, 2'd0, 1'b0, 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "timeout");
  end

  initial begin
    pc4  = 32'h0000_1004;
    imm  = 32'hABC0_0000;
    rstn = 1'b0;
    idle_in();
    repeat (2) @(negedge clk);
    chk("rst_wen", o_wen, 0);
    chk("rst_addr", o_addr, 0);
    chk("rst_data", o_data, 0);
    chk("rst_ill", o_ill, 0);
    chk("rst_ready", ready, 1);
    rstn = 1'b1;

    // ALU write, one-cycle pulse
    set_in(1, 2'b00, 1, 5'd5, 32'h1234_5678, 3'd0, 2'd0, 0, 32'd0);
    @(negedge clk);
    chk("alu_wen", o_wen, 1);
    chk("alu_addr", o_addr, 5);
    chk("alu_data", o_data, 32'h1234_5678);
    idle_in();
    @(negedge clk);
    chk("alu_pulse", o_wen, 0);
    chk("alu_hold", o_data, 32'h1234_5678);

    // Same-cycle loads
    set_in(1, 2'b01, 1, 5'd6, 32'd0, 3'd0, 2'd2, 1, 32'h0080_0000);
    @(negedge clk);
    chk("lb_data", o_data, 32'hFFFF_FF80);
    set_in(1, 2'b01, 1, 5'd6, 32'd0, 3'd5, 2'd2, 1, 32'h8001_0000);
    @(negedge clk);
    chk("lhu_data", o_data, 32'h0000_8001);

    // LW with rvalid 3 cycles late, a competing instruction presented meanwhile
    set_in(1, 2'b01, 1, 5'd9, 32'd0, 3'd2, 2'd0, 0, 32'd0);
    @(negedge clk);
    set_in(1, 2'b00, 1, 5'd3, 32'h0000_0BAD, 3'd0, 2'd0, 0, 32'd0);
    chk("lw_ready1", ready, 0);
    @(negedge clk);
    chk("lw_ready2", ready, 0);
    @(negedge clk);
    chk("lw_ready3", ready, 0);
    rvalid = 1'b1;
    rdata  = 32'hDEAD_BEEF;
    @(negedge clk);
    chk("lw_wen", o_wen, 1);
    chk("lw_addr", o_addr, 9);
    chk("lw_data", o_data, 32'hDEAD_BEEF);
    idle_in();
    @(negedge clk);
    chk("lw_noaccept", o_addr, 9);
`ifdef RISCV_WB_INSTRET_EN
    chk("instret_4", o_instret, 4);
`endif

    // x0 write via PC+4
    set_in(1, 2'b10, 1, 5'd0, 32'd0, 3'd0, 2'd0, 0, 32'd0);
    @(negedge clk);
    chk("x0_wen", o_wen, 0);
`ifdef RISCV_WB_INSTRET_EN
    chk("instret_5", o_instret, 5);
`endif
    idle_in();

    // Flush in WAIT_MEM together with rvalid
    set_in(1, 2'b01, 1, 5'd10, 32'd0, 3'd2, 2'd0, 0, 32'd0);
    @(negedge clk);
    set_in(0, 2'b00, 0, 5'd0, 32'd0, 3'd0, 2'd0, 1, 32'h1111_1111);
    flush = 1'b1;
    @(negedge clk);
    chk("flush_wen", o_wen, 0);
    chk("flush_ready", ready, 1);
    idle_in();

    // Unsupported funct3
    set_in(1, 2'b01, 1, 5'd11, 32'd0, 3'd3, 2'd0, 1, 32'hFFFF_FFFF);
    @(negedge clk);
    chk("ill_pulse", o_ill, 1);
    chk("ill_wen", o_wen, 0);
    chk("ill_data", o_data, 0);
    idle_in();
    @(negedge clk);
    chk("ill_clear", o_ill, 0);
`ifdef RISCV_WB_INSTRET_EN
    chk("instret_6", o_instret, 6);
`endif

    // Flush in IDLE
    set_in(1, 2'b00, 1, 5'd12, 32'h55, 3'd0, 2'd0, 0, 32'd0);
    flush = 1'b1;
    @(negedge clk);
    chk("iflush_wen", o_wen, 0);
    chk("iflush_addr", o_addr, 11);

    // Back-to-back: LH, LBU, IMM
    set_in(1, 2'b01, 1, 5'd1, 32'd0, 3'd1, 2'd0, 1, 32'h1234_8000);
    @(negedge clk);
    chk("lh_data", o_data, 32'hFFFF_8000);
    set_in(1, 2'b01, 1, 5'd2, 32'd0, 3'd4, 2'd3, 1, 32'hFF00_0000);
    @(negedge clk);
    chk("lbu_data", o_data, 32'h0000_00FF);
    set_in(1, 2'b11, 1, 5'd13, 32'd0, 3'd0, 2'd0, 0, 32'd0);
    @(negedge clk);
    chk("imm_data", o_data, 32'hABC0_0000);
    chk("imm_wen", o_wen, 1);
    idle_in();

    // Reset while waiting for load data
    set_in(1, 2'b01, 1, 5'd14, 32'd0, 3'd2, 2'd0, 0, 32'd0);
    @(negedge clk);
    idle_in();
    rstn = 1'b0;
    @(negedge clk);
    rstn = 1'b1;
    chk("wrst_ready", ready, 1);
    chk("wrst_data", o_data, 0);
    chk("wrst_addr", o_addr, 0);
`ifdef RISCV_WB_INSTRET_EN
    chk("wrst_instret", o_instret, 0);
`endif
    rvalid = 1'b1;
    rdata  = 32'h0000_0077;
    @(negedge clk);
    chk("wrst_nowrite", o_wen, 0);
    idle_in();
    repeat (2) @(negedge clk);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/riscv_wb_stage.md
RISCV_WB_STAGE -- requirements
Module: riscv_wb_stage

Interface
REQ-001 Parameter: XLEN (from the shared configs header), default 32, datapath width.
REQ-002 i_clk  input  1  the single clock; all state updates on its rising edge.
REQ-003 i_rstn  input  1  synchronous, active-low reset, sampled on the rising edge of i_clk.
REQ-004 i_wb_valid  input  1  an instruction is presented from MEM/WB.
REQ-005 o_wb_ready  output  1  the stage accepts the presented instruction this cycle.
REQ-006 i_wb_rd_wen / i_wb_rd_addr  input  1/5  instruction writes rd / rd index.
REQ-007 i_wb_src_sel  input  2  writeback source: 00 ALU, 01 MEM, 10 PC+4, 11 IMM.
REQ-008 i_wb_alu_result, i_wb_pc_plus4, i_wb_imm  input  XLEN each  candidate results.
REQ-009 i_wb_funct3 / i_wb_addr_lsb  input  3/2  load type / byte offset of the load address.
REQ-010 i_wb_mem_rvalid / i_wb_mem_rdata  input  1/XLEN  load data return strobe / aligned data word.
REQ-011 i_wb_flush  input  1  discard the pending and presented instruction.
REQ-012 o_regfile_rd_wen / o_regfile_rd_addr / o_regfile_rd_data  output  1/5/XLEN  registered regfile write port.
REQ-013 o_wb_illegal  output  1  one-cycle pulse: unsupported load funct3 retired.

Function
REQ-014 An instruction is accepted when i_wb_valid && o_wb_ready && !i_wb_flush.
REQ-015 FSM states: IDLE, WAIT_MEM; o_wb_ready = 1 in IDLE, 0 in WAIT_MEM.
REQ-016 IDLE, accepted non-load (src != 01), or accepted load with i_wb_mem_rvalid = 1 in the same cycle: write outputs are registered and drive the regfile the next cycle (latency 1); state stays IDLE.
REQ-017 IDLE, accepted load with i_wb_mem_rvalid = 0: rd_wen, rd_addr, funct3 and addr_lsb are captured; state goes to WAIT_MEM.
REQ-018 WAIT_MEM with i_wb_mem_rvalid = 1: the write is registered using the captured fields, driven the next cycle; state returns to IDLE.
REQ-019 o_regfile_rd_wen is a one-cycle pulse equal to captured rd_wen && (rd_addr != 0); x0 is never written.
REQ-020 Load extraction: 000 LB = sign-extended byte at addr_lsb; 001 LH = sign-extended halfword at addr_lsb[1]; 010 LW = full word; 100 LBU / 101 LHU = zero-extended byte / halfword.
REQ-021 Any other load funct3: data = 0, o_regfile_rd_wen = 0, o_wb_illegal pulses in the cycle the write would have occurred.
REQ-022 i_wb_flush in WAIT_MEM: the captured load is dropped, no write, state becomes IDLE next cycle; an i_wb_mem_rvalid in the same cycle is ignored.
REQ-023 i_wb_flush in IDLE: the presented instruction is not accepted and no write is produced.
REQ-024 With no write pending, o_regfile_rd_wen = 0; rd_addr and rd_data hold their last values.

Reset
REQ-025 While i_rstn = 0 at a rising edge: state = IDLE; o_regfile_rd_wen, o_regfile_rd_addr, o_regfile_rd_data and o_wb_illegal = 0; all captured fields = 0.
REQ-026 Reset during WAIT_MEM abandons the load with no write; o_wb_ready = 1 in the first cycle after release.

Configuration
REQ-027 Macro RISCV_WB_INSTRET_EN: when defined, the stage adds output o_wb_instret (64 bits), reset to 0, incremented by 1 in each cycle an instruction completes, whether or not it writes.
REQ-028 A flushed instruction does not increment o_wb_instret; an illegal load does increment it.
REQ-029 o_wb_instret wraps from all-ones to 0.
REQ-030 Without the macro, the port and the counter are absent and all other behaviour is identical.

Structure
REQ-031 Source-select encodings, funct3 load encodings and FSM state encodings are defined as constants in the shared riscv_configs header.
REQ-032 Load extraction is a combinational sub-module riscv_load_align (rdata, funct3, addr_lsb -> data, illegal).

Verification
REQ-033 ALU op, rd = 5, alu_result = 0x1234_5678 -> next cycle wen = 1, addr = 5, data = 0x1234_5678, for one cycle only.
REQ-034 LB, addr_lsb = 2, rdata = 0x0080_0000, rvalid same cycle -> data = 0xFFFF_FF80; LHU, addr_lsb = 2, rdata = 0x8001_0000 -> data = 0x0000_8001.
REQ-035 LW with rvalid 3 cycles late, rdata = 0xDEAD_BEEF -> ready = 0 for 3 cycles, then write of 0xDEAD_BEEF the cycle after rvalid; a new valid presented meanwhile is not accepted.
REQ-036 Write to rd = 0 with src = PC+4 -> wen stays 0; instret (when enabled) increments by 1.
REQ-037 Flush asserted while in WAIT_MEM together with rvalid -> no write, ready = 1 next cycle; funct3 = 011 load -> o_wb_illegal pulse, wen = 0.
REQ-038 i_rstn = 0 asserted in WAIT_MEM -> all outputs 0 and ready = 1 after release; instret = 0.
